// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : disp_pkg
// Description : Shared types and constants for the three-digit display
//               scanner (slot state, digit index, blank segment pattern).
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  // Per-slot phase: all digits dark, then the active digit lit.
  typedef enum logic [0:0] {
    GUARD = 1'b0,
    ON    = 1'b1
  } state_t;

  // Digit index runs 1..3; the value 0 is never used.
  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIG1 = 2'd1;
  localparam digit_idx_t DIG2 = 2'd2;
  localparam digit_idx_t DIG3 = 2'd3;

  // Active-low segments, all off.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7_hex.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex
// Description : Combinational 4-bit hex to 7-segment decoder, active-low,
//               segments a..g on bit0..bit6.
// Ports       : hex_i [3:0] value to show
//               seg_o [6:0] active-low segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/disp_scan_3d.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_3d
// Description : Time-multiplexed driver for a three-digit 7-segment display.
//               Each digit slot lasts SCAN_DIV cycles, the first GUARD_CYCLES
//               of which keep every digit dark. New digit values are staged
//               in a pending register and only take effect at the frame
//               boundary (digit 3 -> digit 1), so a frame never mixes values.
// Options     : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//               (digit 1, and digit 2 if digit 1 is also zero) stay dark.
// Ports       : clk, rst        clock, synchronous active-high reset
//               en              1 = scan, 0 = all digits off
//               upd, d1..d3     load request and hex digit values
//               upd_ack, pend   handshake status
//               rd1..rd3        active-low digit enables
//               seg[6:0]        active-low segments a..g
//               frame_tick      pulse at each frame boundary
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_3d #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       upd,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic       upd_ack,
  output logic       pend,
  output logic       rd1,
  output logic       rd2,
  output logic       rd3,
  output logic [6:0] seg,
  output logic       frame_tick
);
  import disp_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

  state_t            state_q, state_d;
  digit_idx_t        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0][3:0]   disp_q, disp_d;   // [0] = digit 1
  logic [2:0][3:0]   pval_q, pval_d;
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
  logic              tick_q, tick_d;
  logic [2:0]        rd_q, rd_d;       // [0] = rd1
  logic [6:0]        seg_q, seg_d;
  logic              wrap;
  logic [3:0]        cur_hex;
  logic [6:0]        cur_seg;
  logic              blank;

  // Scan sequencing and update handshake.
  always_comb begin
    wrap    = en && (cnt_q == CNT_LAST) && (idx_q == DIG3);
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    tick_d  = wrap;

    if (!en) begin
      state_d = GUARD;
      idx_d   = DIG1;
      cnt_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = GUARD;
      cnt_d   = '0;
      idx_d   = (idx_q == DIG3) ? DIG1 : idx_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_d >= GUARD_END) ? ON : GUARD;
    end

    // The swap uses the value pending before this edge; an upd sampled on
    // the same edge is staged afterwards and waits for the next boundary.
    if (wrap && pend_q) begin
      disp_d = pval_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end
    if (upd) begin
      pval_d = {d3, d2, d1};
      pend_d = 1'b1;
    end
  end

  // Outputs are computed from the next state so the pins line up with the
  // registered state in the same cycle.
  always_comb begin
    case (idx_d)
      DIG1:    cur_hex = disp_d[0];
      DIG2:    cur_hex = disp_d[1];
      default: cur_hex = disp_d[2];
    endcase
  end

  seg7_hex u_dec (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_d)
      DIG1:    blank = (disp_d[0] == 4'h0);
      DIG2:    blank = (disp_d[0] == 4'h0) && (disp_d[1] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    rd_d  = 3'b111;
    seg_d = SEG_OFF;
    if (en && (state_d == ON) && !blank) begin
      seg_d = cur_seg;
      case (idx_d)
        DIG1:    rd_d = 3'b110;
        DIG2:    rd_d = 3'b101;
        default: rd_d = 3'b011;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GUARD;
      idx_q   <= DIG1;
      cnt_q   <= '0;
      disp_q  <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      tick_q  <= 1'b0;
      rd_q    <= 3'b111;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      tick_q  <= tick_d;
      rd_q    <= rd_d;
      seg_q   <= seg_d;
    end
  end

  assign rd1        = rd_q[0];
  assign rd2        = rd_q[1];
  assign rd3        = rd_q[2];
  assign seg        = seg_q;
  assign upd_ack    = ack_q;
  assign pend       = pend_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_3d.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_scan_3d
// Description : Self-checking bench for disp_scan_3d with SCAN_DIV=8,
//               GUARD_CYCLES=2. A position-in-frame reference model predicts
//               every output pin each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan_3d;

  localparam int SD = 8;
  localparam int GC = 2;
  localparam int FRAME = 3 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       upd = 1'b0;
  logic [3:0] d1 = '0, d2 = '0, d3 = '0;
  logic       upd_ack, pend, rd1, rd2, rd3, frame_tick;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  disp_scan_3d #(.SCAN_DIV(SD), .GUARD_CYCLES(GC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .upd(upd),
    .d1(d1), .d2(d2), .d3(d3),
    .upd_ack(upd_ack), .pend(pend),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position in frame plus displayed/pending digit values.
  logic [6:0]  segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_pos = 0;
  logic [3:0]  m_disp [3] = '{4'h0, 4'h0, 4'h0};
  logic [3:0]  m_pend [3] = '{4'h0, 4'h0, 4'h0};
  logic        m_pendf = 1'b0;
  logic        e_ack, e_tick;
  logic [2:0]  e_rd;
  logic [6:0]  e_seg;
  logic [12:0] e_vec;
  wire  [12:0] dut_vec = {rd1, rd2, rd3, seg, upd_ack, pend, frame_tick};

  task automatic model_step();
    int  slot;
    bit  blank;
    e_ack  = 1'b0;
    e_tick = 1'b0;
    if (rst) begin
      m_pos   = 0;
      m_disp  = '{4'h0, 4'h0, 4'h0};
      m_pend  = '{4'h0, 4'h0, 4'h0};
      m_pendf = 1'b0;
    end else begin
      if (en) begin
        if (m_pos == FRAME - 1) begin
          e_tick = 1'b1;
          if (m_pendf) begin
            m_disp  = m_pend;
            m_pendf = 1'b0;
            e_ack   = 1'b1;
          end
        end
        m_pos = (m_pos + 1) % FRAME;
      end else begin
        m_pos = 0;
      end
      if (upd) begin
        m_pend  = '{d1, d2, d3};
        m_pendf = 1'b1;
      end
    end
    e_rd  = 3'b111;
    e_seg = 7'h7F;
    if (!rst && en && (m_pos % SD) >= GC) begin
      slot  = m_pos / SD;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot == 0) blank = (m_disp[0] == 4'h0);
      if (slot == 1) blank = (m_disp[0] == 4'h0) && (m_disp[1] == 4'h0);
`endif
      if (!blank) begin
        e_rd[slot] = 1'b0;
        e_seg      = segtab[m_disp[slot]];
      end
    end
    e_vec = {e_rd[0], e_rd[1], e_rd[2], e_seg, e_ack, m_pendf, e_tick};
  endtask

  // Advance one clock: the DUT and model both see the inputs held since the
  // previous falling edge; outputs are then sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; upd = 1'b0;
    step(); step();
    checks++;
    if (dut_vec !== 13'h1FF8) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 13'h1FF8);
    end
    rst = 1'b0;
    step();
    checks++;
    if (dut_vec !== e_vec) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", dut_vec, e_vec);
    end
  endtask

  task automatic test_basic();
    int first_tick = 0;
    int ack_at = 0;
    en = 1'b1; upd = 1'b1; d1 = 4'd1; d2 = 4'd2; d3 = 4'd3;
    for (int n = 1; n <= 2 * FRAME; n++) begin
      step();
      upd = 1'b0;
      checks++;
      if (dut_vec !== e_vec) begin
        errors++;
        $display("FAIL basic n=%0d got=%h exp=%h", n, dut_vec, e_vec);
      end
      checks++;
      if ((32'(rd1) + 32'(rd2) + 32'(rd3)) < 2) begin
        errors++;
        $display("FAIL basic_one_digit n=%0d got rd=%b%b%b exp at most one low", n, rd1, rd2, rd3);
      end
      if (frame_tick && first_tick == 0) first_tick = n;
      if (upd_ack && ack_at == 0) ack_at = n;
      if (n == FRAME + SD + GC) begin
        checks++;
        if ({rd1, rd2, rd3, seg} !== {3'b101, 7'h24}) begin
          errors++;
          $display("FAIL basic_digit2 got=%b%b%b/%h exp=101/24", rd1, rd2, rd3, seg);
        end
      end
    end
    checks++;
    if (first_tick != FRAME || ack_at != FRAME) begin
      errors++;
      $display("FAIL basic_first_tick got tick=%0d ack=%0d exp=%0d", first_tick, ack_at, FRAME);
    end
  endtask

  task automatic test_double_upd();
    int acks = 0;
    for (int n = 1; n <= 2 * FRAME; n++) begin
      upd = (n == 3) || (n == 10);
      if (n == 3)  begin d1 = 4'd4; d2 = 4'd5; d3 = 4'd6; end
      if (n == 10) begin d1 = 4'd7; d2 = 4'd8; d3 = 4'd9; end
      step();
      if (upd_ack) acks++;
      checks++;
      if (dut_vec !== e_vec) begin
        errors++;
        $display("FAIL double_upd n=%0d got=%h exp=%h", n, dut_vec, e_vec);
      end
    end
    upd = 1'b0;
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL double_upd_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_disable();
    int guard = 0;
    while (m_pos != SD + 4 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    checks++;
    if (m_pos != SD + 4) begin
      errors++;
      $display("FAIL disable_reach got pos=%0d exp=%0d", m_pos, SD + 4);
    end
    en = 1'b0;
    for (int n = 0; n < 6; n++) begin
      upd = (n == 2);
      d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      step();
      checks++;
      if (dut_vec !== e_vec || {rd1, rd2, rd3, seg, upd_ack} !== {3'b111, 7'h7F, 1'b0}) begin
        errors++;
        $display("FAIL disable_off n=%0d got=%h exp=%h", n, dut_vec, e_vec);
      end
    end
    upd = 1'b0; en = 1'b1;
    for (int n = 1; n <= FRAME + 4; n++) begin
      step();
      checks++;
      if (dut_vec !== e_vec) begin
        errors++;
        $display("FAIL disable_resume n=%0d got=%h exp=%h", n, dut_vec, e_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    upd = 1'b1; d1 = 4'hA; d2 = 4'hB; d3 = 4'hC;
    step();
    upd = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dut_vec !== 13'h1FF8) begin
      errors++;
      $display("FAIL reset_mid_state got=%h exp=%h", dut_vec, 13'h1FF8);
    end
    for (int n = 1; n <= 2 * FRAME; n++) begin
      step();
      if (upd_ack) acks++;
      checks++;
      if (dut_vec !== e_vec) begin
        errors++;
        $display("FAIL reset_mid n=%0d got=%h exp=%h", n, dut_vec, e_vec);
      end
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_mid_acks got=%0d exp=0", acks);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 79) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      upd = ($urandom_range(0, 9) == 0);
      d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      step();
      checks++;
      if (dut_vec !== e_vec) begin
        errors++;
        $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec, e_vec);
      end
    end
    rst = 1'b0; upd = 1'b0; en = 1'b1;
  endtask

  task automatic test_leading_zero();
    int guard = 0;
    upd = 1'b1; d1 = 4'd0; d2 = 4'd0; d3 = 4'd5;
    step();
    upd = 1'b0;
    while (!upd_ack && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    checks++;
    if (!upd_ack) begin
      errors++;
      $display("FAIL lzb_ack got=0 exp=1");
    end
    for (int n = 1; n <= FRAME; n++) begin
      step();
      checks++;
      if (dut_vec !== e_vec) begin
        errors++;
        $display("FAIL lzb n=%0d got=%h exp=%h", n, dut_vec, e_vec);
      end
`ifdef LEADING_ZERO_BLANK_EN
      checks++;
      if (!rd1 || !rd2 || (!rd3 && seg !== 7'h12)) begin
        errors++;
        $display("FAIL lzb_blank n=%0d got rd=%b%b%b seg=%h exp rd1=rd2=1 seg=12", n, rd1, rd2, rd3, seg);
      end
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_double_upd();
    test_disable();
    test_reset_mid();
    test_random();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
